// File: rtl/avr_trace_pkg.sv
// avr_trace_pkg
// Shared types for the program-memory fetch tracer:
//   PAW         program address width in words
//   trace_rec_t one instruction record as seen by the trace consumer
//   fsm_t       word-pairing state (W0: expecting first word, W1: holding it)
//   is32()      true for opcodes that carry a second word (lds/sts/jmp/call)
package avr_trace_pkg;

  localparam int PAW = 16;

  typedef struct packed {
    logic [PAW-1:0] adr;
    logic [15:0]    w0;
    logic [15:0]    w1;
    logic           is32;
    logic           err;
  } trace_rec_t;

  typedef enum logic {
    W0 = 1'b0,
    W1 = 1'b1
  } fsm_t;

  // lds/sts : 1001_00?x_xxxx_0000
  // jmp/call: 1001_010x_xxxx_11xx
  function automatic logic is32(input logic [15:0] w);
    logic ldst;
    logic jmpcall;
    ldst    = (w[15:10] == 6'b100100) && (w[3:0] == 4'b0000);
    jmpcall = (w[15:9] == 7'b1001010) && (w[3:2] == 2'b11);
    return ldst | jmpcall;
  endfunction

endpackage

// File: rtl/avr_fetch_tracer_if.sv
// avr_fetch_tracer_if
// Bundles the fetch-side strobe, the trace valid/ready channel and the
// status outputs of the tracer.
//   master: the surrounding system (core fetch + trace consumer)
//   slave : the tracer itself
interface avr_fetch_tracer_if #(
  parameter int CW = 16
);
  import avr_trace_pkg::*;

  logic           if_vld;
  logic [PAW-1:0] if_adr;
  logic [15:0]    if_dat;
  logic           if_flush;
  logic           tr_vld;
  logic           tr_rdy;
  trace_rec_t     tr_rec;
  logic           ovf;
  logic [CW-1:0]  drop_cnt;
  logic           pend;

  modport master (
    output if_vld, if_adr, if_dat, if_flush, tr_rdy,
    input  tr_vld, tr_rec, ovf, drop_cnt, pend
  );

  modport slave (
    input  if_vld, if_adr, if_dat, if_flush, tr_rdy,
    output tr_vld, tr_rec, ovf, drop_cnt, pend
  );

endinterface

// File: rtl/avr_trace_fifo.sv
// avr_trace_fifo
// Show-ahead record FIFO with a write port taking 0, 1 or 2 records per cycle.
//   clk, rst    clock, synchronous active-high reset
//   wr_cnt_i    number of records to write this cycle (0..2), dat0 first
//   wr_dat0_i   first record
//   wr_dat1_i   second record (written only when wr_cnt_i == 2)
//   rd_i        pop the head (ignored when empty)
//   rd_dat_o    head record
//   full_o      no free slot
//   empty_o     no record held
//   free_cnt_o  number of free slots
// The caller never writes more records than free_cnt_o plus a same-cycle pop.
module avr_trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type rec_t = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             wr_cnt_i,
  input  rec_t                   wr_dat0_i,
  input  rec_t                   wr_dat1_i,
  input  logic                   rd_i,
  output rec_t                   rd_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] free_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  rec_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW-1:0] used;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign used       = wr_ptr_q - rd_ptr_q;
  assign free_cnt_o = PW'(DEPTH) - used;
  assign wr_ptr_p1  = wr_ptr_q + PW'(1);
  assign rd_dat_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(wr_cnt_i);
      if (rd_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage is not reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (wr_cnt_i != 2'd0) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat0_i;
    end
    if (wr_cnt_i == 2'd2) begin
      mem_q[wr_ptr_p1[AW-1:0]] <= wr_dat1_i;
    end
  end

endmodule

// File: rtl/avr_fetch_tracer.sv
// avr_fetch_tracer
// Passive monitor on the program-memory fetch interface. Pairs the words of
// 32-bit opcodes into one record, buffers records and hands them to a trace
// consumer over valid/ready. The core is never stalled: records that find no
// free slot are dropped and counted.
//   clk, rst        clock, synchronous active-high reset
//   bus.if_vld      fetch strobe
//   bus.if_adr      word address of the fetched word
//   bus.if_dat      fetched word
//   bus.if_flush    pipeline flush, discards a held first word
//   bus.tr_vld      record available
//   bus.tr_rdy      consumer accepts the record
//   bus.tr_rec      head record
//   bus.ovf         sticky: at least one record dropped
//   bus.drop_cnt    saturating count of dropped records
//   bus.pend        first word of a 32-bit pair is held
module avr_fetch_tracer
  import avr_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input logic               clk,
  input logic               rst,
  avr_fetch_tracer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 2;

  fsm_t           state_q, state_d;
  logic [PAW-1:0] hold_adr_q, hold_adr_d;
  logic [15:0]    hold_w0_q, hold_w0_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  drop_q, drop_d;

  trace_rec_t     rec_a;
  trace_rec_t     rec_b;
  trace_rec_t     cur_rec;
  logic [1:0]     n_push;
  logic [1:0]     n_acc;
  logic [1:0]     n_drop;
  logic [PAW-1:0] hold_adr_p1;
  logic [FW-1:0]  free_eff;
  logic [CW:0]    drop_sum;

  logic           fifo_empty;
  logic           fifo_full;
  logic [AW:0]    fifo_free;
  trace_rec_t     fifo_head;
  logic           pop;

  assign hold_adr_p1 = hold_adr_q + PAW'(1);
  assign pop         = !fifo_empty && bus.tr_rdy;

  // Pairing FSM. Records to push are packed into rec_a/rec_b in issue order.
  always_comb begin
    state_d    = state_q;
    hold_adr_d = hold_adr_q;
    hold_w0_d  = hold_w0_q;
    rec_a      = '0;
    rec_b      = '0;
    n_push     = 2'd0;
    cur_rec    = '0;
    cur_rec.adr = bus.if_adr;
    cur_rec.w0  = bus.if_dat;

    if (bus.if_flush) begin
      state_d = W0;
    end else if (bus.if_vld) begin
      if (state_q == W1 && bus.if_adr == hold_adr_p1) begin
        rec_a.adr  = hold_adr_q;
        rec_a.w0   = hold_w0_q;
        rec_a.w1   = bus.if_dat;
        rec_a.is32 = 1'b1;
        n_push     = 2'd1;
        state_d    = W0;
      end else begin
        // A broken pair is reported first, then the current word is
        // handled as a fresh first word in the same cycle.
        if (state_q == W1) begin
          rec_a.adr  = hold_adr_q;
          rec_a.w0   = hold_w0_q;
          rec_a.is32 = 1'b1;
          rec_a.err  = 1'b1;
          n_push     = 2'd1;
        end
        if (is32(bus.if_dat)) begin
          state_d    = W1;
          hold_adr_d = bus.if_adr;
          hold_w0_d  = bus.if_dat;
        end else begin
          state_d = W0;
          if (n_push == 2'd0) begin
            rec_a = cur_rec;
          end else begin
            rec_b = cur_rec;
          end
          n_push = n_push + 2'd1;
        end
      end
    end
  end

  // A same-cycle pop frees a slot; records beyond the free space are dropped,
  // and since they are packed in order the later one is dropped first.
  always_comb begin
    free_eff = {1'b0, fifo_free} + FW'(pop);
    if (FW'(n_push) <= free_eff) begin
      n_acc = n_push;
    end else begin
      n_acc = free_eff[1:0];
    end
    n_drop   = n_push - n_acc;
    drop_sum = {1'b0, drop_q} + (CW+1)'(n_drop);
    drop_d   = drop_sum[CW] ? '1 : drop_sum[CW-1:0];
    ovf_d    = ovf_q | (n_drop != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= W0;
      hold_adr_q <= '0;
      hold_w0_q  <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_adr_q <= hold_adr_d;
      hold_w0_q  <= hold_w0_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  avr_trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_cnt_i   (n_acc),
    .wr_dat0_i  (rec_a),
    .wr_dat1_i  (rec_b),
    .rd_i       (pop),
    .rd_dat_o   (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .free_cnt_o (fifo_free)
  );

  assign bus.tr_vld   = !fifo_empty;
  assign bus.tr_rec   = fifo_head;
  assign bus.ovf      = ovf_q;
  assign bus.drop_cnt = drop_q;
  assign bus.pend     = (state_q == W1);

  // Full is implied by free_cnt; kept as a port of the FIFO for other users.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_avr_fetch_tracer.sv
// tb_avr_fetch_tracer
// Table-driven vectors, hand-written multi-cycle sequences and a randomized
// run against a queue-based reference model of the tracer.
module tb_avr_fetch_tracer;
  import avr_trace_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avr_fetch_tracer_if #(.CW(CW)) bus ();

  avr_fetch_tracer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        vld;
    logic        flush;
    logic        rdy;
    logic [15:0] adr;
    logic [15:0] dat;
    logic        exp_vld;
    logic        exp_pend;
    trace_rec_t  exp_rec;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  trace_rec_t mq[$];
  trace_rec_t hq[$];
  int         mdrops;
  bit         movf;

  function automatic trace_rec_t mkrec(input logic [15:0] a, input logic [15:0] w0,
                                       input logic [15:0] w1, input logic i, input logic e);
    trace_rec_t r;
    r.adr = a; r.w0 = w0; r.w1 = w1; r.is32 = i; r.err = e;
    return r;
  endfunction

  function automatic vec_t mkvec(input logic v, input logic f, input logic r,
                                 input logic [15:0] a, input logic [15:0] d,
                                 input logic ev, input logic ep, input trace_rec_t er);
    vec_t x;
    x.vld = v; x.flush = f; x.rdy = r; x.adr = a; x.dat = d;
    x.exp_vld = ev; x.exp_pend = ep; x.exp_rec = er;
    return x;
  endfunction

  function automatic bit ref_is32(input logic [15:0] w);
    return (w ==? 16'b1001_00??_????_0000) || (w ==? 16'b1001_010?_????_11??);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [15:0] a,
                       input logic [15:0] d, input logic r);
    bus.if_vld = v; bus.if_flush = f; bus.if_adr = a; bus.if_dat = d; bus.tr_rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  // One cycle of the reference model, evaluated with pre-edge state.
  task automatic model_step(input logic v, input logic f, input logic [15:0] a,
                            input logic [15:0] d, input logic r);
    trace_rec_t pushes[$];
    trace_rec_t h;
    logic [15:0] nx;
    bit consumed;
    consumed = 0;
    if (r && mq.size() != 0) begin
      $display("pop adr=%h w0=%h w1=%h is32=%b err=%b",
               mq[0].adr, mq[0].w0, mq[0].w1, mq[0].is32, mq[0].err);
      void'(mq.pop_front());
    end
    if (f) begin
      hq.delete();
    end else if (v) begin
      if (hq.size() != 0) begin
        h  = hq.pop_front();
        nx = h.adr + 16'd1;
        if (a == nx) begin
          h.w1 = d;
          consumed = 1;
        end else begin
          h.err = 1'b1;
        end
        pushes.push_back(h);
      end
      if (!consumed) begin
        if (ref_is32(d)) hq.push_back(mkrec(a, d, 16'h0, 1'b1, 1'b0));
        else pushes.push_back(mkrec(a, d, 16'h0, 1'b0, 1'b0));
      end
    end
    foreach (pushes[k]) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(pushes[k]);
      end else begin
        movf = 1;
        if (mdrops < 65535) mdrops++;
      end
    end
  endtask

  initial begin
    logic        v, f, r, rs;
    logic [15:0] a, d, last_adr;
    int          bias;
    logic [15:0] order[$];

    // ---------------- reset state ----------------
    do_reset();
    tick();
    chk("reset.tr_vld", 64'(bus.tr_vld), 64'd0);
    chk("reset.pend", 64'(bus.pend), 64'd0);
    chk("reset.ovf", 64'(bus.ovf), 64'd0);
    chk("reset.drop_cnt", 64'(bus.drop_cnt), 64'd0);

    // ---------------- vector table ----------------
    vecs.push_back(mkvec(1, 0, 0, 16'h0000, 16'h0000, 1, 0, mkrec(16'h0000, 16'h0000, 16'h0000, 0, 0)));
    vecs.push_back(mkvec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'h0010, 16'h940C, 0, 1, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'h0011, 16'h0123, 1, 0, mkrec(16'h0010, 16'h940C, 16'h0123, 1, 0)));
    vecs.push_back(mkvec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'h0020, 16'h9100, 0, 1, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'h0030, 16'h0000, 1, 0, mkrec(16'h0020, 16'h9100, 16'h0000, 1, 1)));
    vecs.push_back(mkvec(0, 0, 1, 16'h0000, 16'h0000, 1, 0, mkrec(16'h0030, 16'h0000, 16'h0000, 0, 0)));
    vecs.push_back(mkvec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'h0040, 16'h940E, 0, 1, '0));
    vecs.push_back(mkvec(1, 1, 0, 16'h0041, 16'h1234, 0, 0, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'h0050, 16'h9201, 1, 0, mkrec(16'h0050, 16'h9201, 16'h0000, 0, 0)));
    vecs.push_back(mkvec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'hFFFF, 16'h9200, 0, 1, '0));
    vecs.push_back(mkvec(1, 0, 0, 16'h0000, 16'h5555, 1, 0, mkrec(16'hFFFF, 16'h9200, 16'h5555, 1, 0)));
    vecs.push_back(mkvec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, '0));
    vecs.push_back(mkvec(1, 1, 0, 16'h0060, 16'h0001, 0, 0, '0));
    vecs.push_back(mkvec(0, 0, 0, 16'h0000, 16'h0000, 0, 0, '0));

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].flush, vecs[i].adr, vecs[i].dat, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d.tr_vld", i), 64'(bus.tr_vld), 64'(vecs[i].exp_vld));
      chk($sformatf("vec%0d.pend", i), 64'(bus.pend), 64'(vecs[i].exp_pend));
      if (vecs[i].exp_vld) chk($sformatf("vec%0d.rec", i), 64'(bus.tr_rec), 64'(vecs[i].exp_rec));
      $display("vec %0d: vld=%b flush=%b adr=%h dat=%h rdy=%b -> tr_vld=%b pend=%b rec=%h",
               i, vecs[i].vld, vecs[i].flush, vecs[i].adr, vecs[i].dat, vecs[i].rdy,
               bus.tr_vld, bus.pend, bus.tr_rec);
    end

    // ---------------- overflow, then full + pop + push ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 16'h0100 + 16'(i), 16'(i), 0);
      tick();
      $display("fill %0d: drop_cnt=%0d ovf=%b", i, bus.drop_cnt, bus.ovf);
    end
    chk("ovf.tr_vld", 64'(bus.tr_vld), 64'd1);
    chk("ovf.head_adr", 64'(bus.tr_rec.adr), 64'h0100);
    chk("ovf.drop_cnt", 64'(bus.drop_cnt), 64'd2);
    chk("ovf.ovf", 64'(bus.ovf), 64'd1);
    drive(1, 0, 16'h0106, 16'h0006, 1);
    tick();
    $display("full+pop+push: drop_cnt=%0d head=%h", bus.drop_cnt, bus.tr_rec.adr);
    chk("fullpop.drop_cnt", 64'(bus.drop_cnt), 64'd2);
    chk("fullpop.head_adr", 64'(bus.tr_rec.adr), 64'h0101);
    order = '{16'h0102, 16'h0103, 16'h0106};
    foreach (order[k]) begin
      drive(0, 0, 16'h0, 16'h0, 1);
      tick();
      $display("drain %0d: tr_vld=%b head=%h", k, bus.tr_vld, bus.tr_rec.adr);
      chk($sformatf("drain%0d.tr_vld", k), 64'(bus.tr_vld), 64'd1);
      chk($sformatf("drain%0d.head_adr", k), 64'(bus.tr_rec.adr), 64'(order[k]));
    end
    drive(0, 0, 16'h0, 16'h0, 1);
    tick();
    chk("drain.empty", 64'(bus.tr_vld), 64'd0);

    // ---------------- full FIFO, broken pair: two drops in one cycle ------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 16'h0200 + 16'(i), 16'h0000, 0);
      tick();
    end
    drive(1, 0, 16'h0300, 16'h940C, 0);
    tick();
    drive(1, 0, 16'h0310, 16'h0000, 0);
    tick();
    $display("double drop: drop_cnt=%0d ovf=%b pend=%b", bus.drop_cnt, bus.ovf, bus.pend);
    chk("dbl.drop_cnt", 64'(bus.drop_cnt), 64'd2);
    chk("dbl.pend", 64'(bus.pend), 64'd0);
    chk("dbl.head_adr", 64'(bus.tr_rec.adr), 64'h0200);

    // ---------------- reset mid-pair ----------------
    do_reset();
    drive(1, 0, 16'h0180, 16'h0000, 0);
    tick();
    drive(1, 0, 16'h0200, 16'h940C, 0);
    tick();
    chk("midrst.pend_before", 64'(bus.pend), 64'd1);
    do_reset();
    $display("reset mid-pair: pend=%b tr_vld=%b", bus.pend, bus.tr_vld);
    chk("midrst.pend", 64'(bus.pend), 64'd0);
    chk("midrst.tr_vld", 64'(bus.tr_vld), 64'd0);
    drive(1, 0, 16'h0201, 16'h0123, 0);
    tick();
    chk("midrst.next_rec", 64'(bus.tr_rec), 64'(mkrec(16'h0201, 16'h0123, 16'h0000, 0, 0)));
    chk("midrst.next_vld", 64'(bus.tr_vld), 64'd1);

    // ---------------- randomized run against the reference model ----------
    do_reset();
    mq.delete(); hq.delete(); mdrops = 0; movf = 0;
    last_adr = 16'h0;
    bias = 2;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) bias = $urandom_range(0, 4);
      v  = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 3) < bias);
      rs = ($urandom_range(0, 249) == 0);
      a  = ($urandom_range(0, 9) < 6) ? last_adr + 16'd1 : 16'($urandom);
      case ($urandom_range(0, 3))
        0: d = 16'($urandom);
        1: d = 16'h940C | (16'($urandom) & 16'h01F3);
        2: d = 16'h9000 | (16'($urandom) & 16'h03F0);
        default: d = 16'($urandom) & 16'h3FFF;
      endcase
      if (v) last_adr = a;
      drive(v, f, a, d, r);
      rst = rs;
      if (rs) begin
        mq.delete(); hq.delete(); mdrops = 0; movf = 0;
      end else begin
        model_step(v, f, a, d, r);
      end
      tick();
      rst = 1'b0;
      chk($sformatf("rnd%0d.tr_vld", c), 64'(bus.tr_vld), 64'(mq.size() != 0));
      if (mq.size() != 0) chk($sformatf("rnd%0d.rec", c), 64'(bus.tr_rec), 64'(mq[0]));
      chk($sformatf("rnd%0d.pend", c), 64'(bus.pend), 64'(hq.size() != 0));
      chk($sformatf("rnd%0d.drop_cnt", c), 64'(bus.drop_cnt), 64'(mdrops));
      chk($sformatf("rnd%0d.ovf", c), 64'(bus.ovf), 64'(movf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
